// File: rtl/video_stream_pattern_gen.sv
// -----------------------------------------------------------------------------
// video_stream_pattern_gen
//
// AXI4-Stream video source. Emits complete frames of a selectable test
// pattern using the video sideband: tuser marks start-of-frame (first pixel
// of line 0), tlast marks end-of-line (last pixel of every line).
//
// Optional build macro:
//   VIDEO_STREAM_PATTERN_GEN_FRAME_CNT_EN - adds the frame_count output, a
//   32-bit wrapping count of completed frames (cleared only by areset).
//
// Ports:
//   aclk, areset            clock, asynchronous active-high reset
//   start                   level; frames are generated back-to-back while high
//   frame_width/height      geometry, sampled at each frame start
//   pattern_sel             0 h-ramp, 1 v-ramp, 2 8x8 checkerboard, 3 solid
//   m_axis_video_*          AXI4-Stream master (id/dest tied 0, keep/strb 1s)
//   busy                    high while a frame is in progress
//   frame_done              one-cycle pulse after the final beat of a frame
//   state_dbg               current FSM state (0 idle, 1 run) for checkers
//
// Handshake: a beat transfers on a rising edge where tvalid & tready are both
// high. Once tvalid is raised it stays high until that beat transfers, and
// tdata/tlast/tuser do not change while the beat waits. tvalid only drops
// between frames.
// -----------------------------------------------------------------------------
module video_stream_pattern_gen #(
    parameter int          VIDEO_DATA_WIDTH = 24,
    parameter int          DIM_WIDTH        = 12,
    parameter logic [23:0] SOLID_COLOR      = 24'h00FF00
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          start,
    input  logic [DIM_WIDTH-1:0]          frame_width,
    input  logic [DIM_WIDTH-1:0]          frame_height,
    input  logic [1:0]                    pattern_sel,
    output logic [VIDEO_DATA_WIDTH-1:0]   m_axis_video_tdata,
    output logic                          m_axis_video_tvalid,
    input  logic                          m_axis_video_tready,
    output logic                          m_axis_video_tlast,
    output logic                          m_axis_video_tuser,
    output logic                          m_axis_video_id,
    output logic [VIDEO_DATA_WIDTH/8-1:0] m_axis_video_keep,
    output logic [VIDEO_DATA_WIDTH/8-1:0] m_axis_video_strb,
    output logic                          m_axis_video_dest,
    output logic                          busy,
    output logic                          frame_done,
`ifdef VIDEO_STREAM_PATTERN_GEN_FRAME_CNT_EN
    output logic [31:0]                   frame_count,
`endif
    output logic                          state_dbg
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [DIM_WIDTH-1:0]        ONE       = DIM_WIDTH'(1);
    localparam logic [VIDEO_DATA_WIDTH-1:0] SOLID_PIX = VIDEO_DATA_WIDTH'(SOLID_COLOR);

    // Pixel value for a coordinate. Only the low byte of each counter
    // matters: ramps wrap every 256 and the checkerboard uses bit 3.
    function automatic logic [VIDEO_DATA_WIDTH-1:0] pixel(
        input logic [7:0] xb,
        input logic [7:0] yb,
        input logic [1:0] pat
    );
        logic [7:0] b;
        b = 8'h00;
        case (pat)
            2'd0:    b = xb;
            2'd1:    b = yb;
            2'd2:    b = (xb[3] ^ yb[3]) ? 8'hFF : 8'h00;
            default: b = 8'h00;
        endcase
        if (pat == 2'd3) begin
            pixel = SOLID_PIX;
        end else begin
            pixel = {(VIDEO_DATA_WIDTH/8){b}};
        end
    endfunction

    state_t                        state_q, state_d;
    logic [DIM_WIDTH-1:0]          x_q, x_d;
    logic [DIM_WIDTH-1:0]          y_q, y_d;
    logic [DIM_WIDTH-1:0]          w_q, w_d;
    logic [DIM_WIDTH-1:0]          h_q, h_d;
    logic [1:0]                    pat_q, pat_d;
    logic [VIDEO_DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                          tvalid_q, tvalid_d;
    logic                          tlast_q, tlast_d;
    logic                          tuser_q, tuser_d;
    logic                          busy_q, busy_d;
    logic                          frame_done_q, frame_done_d;
`ifdef VIDEO_STREAM_PATTERN_GEN_FRAME_CNT_EN
    logic [31:0]                   frame_count_q, frame_count_d;
`endif

    logic                 geom_ok;
    logic                 beat_xfer;
    logic                 x_last;
    logic                 y_last;
    logic                 load;
    logic [DIM_WIDTH-1:0] w_m1;
    logic [DIM_WIDTH-1:0] h_m1;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        w_d          = w_q;
        h_d          = h_q;
        pat_d        = pat_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        frame_done_d = 1'b0;
        load         = 1'b0;

        geom_ok   = start && (frame_width != '0) && (frame_height != '0);
        beat_xfer = tvalid_q && m_axis_video_tready;
        w_m1      = w_q - ONE;
        h_m1      = h_q - ONE;
        x_last    = (x_q == w_m1);
        y_last    = (y_q == h_m1);

        case (state_q)
            ST_IDLE: begin
                if (geom_ok) begin
                    load = 1'b1;
                end
            end
            ST_RUN: begin
                if (beat_xfer) begin
                    if (x_last && y_last) begin
                        frame_done_d = 1'b1;
                        if (geom_ok) begin
                            // Chain straight into the next frame so tvalid
                            // never drops between back-to-back frames.
                            load = 1'b1;
                        end else begin
                            state_d  = ST_IDLE;
                            tvalid_d = 1'b0;
                            tdata_d  = '0;
                            tlast_d  = 1'b0;
                            tuser_d  = 1'b0;
                        end
                    end else begin
                        if (x_last) begin
                            x_d = '0;
                            y_d = y_q + ONE;
                        end else begin
                            x_d = x_q + ONE;
                        end
                        // Any beat after the first is never at (0,0).
                        tuser_d = 1'b0;
                        tlast_d = (x_d == w_m1);
                        tdata_d = pixel(x_d[7:0], y_d[7:0], pat_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame start: geometry and pattern are captured here and held for
        // the whole frame, so the inputs may change freely mid-frame.
        if (load) begin
            state_d  = ST_RUN;
            w_d      = frame_width;
            h_d      = frame_height;
            pat_d    = pattern_sel;
            x_d      = '0;
            y_d      = '0;
            tvalid_d = 1'b1;
            tuser_d  = 1'b1;
            tlast_d  = (frame_width == ONE);
            tdata_d  = pixel(8'h00, 8'h00, pattern_sel);
        end

        busy_d = (state_d == ST_RUN);
    end

`ifdef VIDEO_STREAM_PATTERN_GEN_FRAME_CNT_EN
    // Steps on the same edge that raises frame_done, so the new count is
    // visible in the cycle the pulse is high.
    always_comb begin
        frame_count_d = frame_count_q;
        if (frame_done_d) begin
            frame_count_d = frame_count_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            w_q          <= '0;
            h_q          <= '0;
            pat_q        <= 2'd0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef VIDEO_STREAM_PATTERN_GEN_FRAME_CNT_EN
            frame_count_q <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            w_q          <= w_d;
            h_q          <= h_d;
            pat_q        <= pat_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef VIDEO_STREAM_PATTERN_GEN_FRAME_CNT_EN
            frame_count_q <= frame_count_d;
`endif
        end
    end

    assign m_axis_video_tdata  = tdata_q;
    assign m_axis_video_tvalid = tvalid_q;
    assign m_axis_video_tlast  = tlast_q;
    assign m_axis_video_tuser  = tuser_q;
    assign m_axis_video_id     = 1'b0;
    assign m_axis_video_keep   = '1;
    assign m_axis_video_strb   = '1;
    assign m_axis_video_dest   = 1'b0;
    assign busy                = busy_q;
    assign frame_done          = frame_done_q;
    assign state_dbg           = state_q;
`ifdef VIDEO_STREAM_PATTERN_GEN_FRAME_CNT_EN
    assign frame_count         = frame_count_q;
`endif

endmodule

// File: doc/video_stream_pattern_gen.md
Name: video_stream_pattern_gen

Overview:
- AXI4-Stream video source: the transmit end of the video stream that the in-line filter IPs consume.
- Generates complete frames with the codebase's video sideband: tuser marks start-of-frame (SOF), tlast marks end-of-line (EOL).
- Frame geometry and pattern come from static control ports; the block honours output backpressure.
- Used as a stimulus source ahead of the filter chain for bring-up and for the regression benches.

Parameters:
- VIDEO_DATA_WIDTH, 24, tdata width; must be a multiple of 8, one byte per colour component.
- DIM_WIDTH, 12, width of the frame_width and frame_height inputs.
- SOLID_COLOR, 24'h00FF00, pixel value for pattern 3; zero-extended or truncated to VIDEO_DATA_WIDTH.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- start  in  1  level; generate frames back-to-back while high
- frame_width  in  DIM_WIDTH  pixels per line, sampled at frame start
- frame_height  in  DIM_WIDTH  lines per frame, sampled at frame start
- pattern_sel  in  2  0 = horizontal ramp, 1 = vertical ramp, 2 = 8x8 checkerboard, 3 = solid colour; sampled at frame start
- m_axis_video_tdata  out  VIDEO_DATA_WIDTH  pixel
- m_axis_video_tvalid  out  1  beat valid
- m_axis_video_tready  in  1  sink ready
- m_axis_video_tlast  out  1  EOL
- m_axis_video_tuser  out  1  SOF
- m_axis_video_id  out  1  constant 0
- m_axis_video_keep  out  VIDEO_DATA_WIDTH/8  constant all ones
- m_axis_video_strb  out  VIDEO_DATA_WIDTH/8  constant all ones
- m_axis_video_dest  out  1  constant 0
- busy  out  1  high while a frame is in progress
- frame_done  out  1  one-cycle pulse on the handshake of the final beat of a frame

Behaviour:
- Clock and reset: single clock aclk; areset is asynchronous and active-high.
- Reset values: tvalid, tdata, tlast, tuser, busy and frame_done are 0; state is IDLE; x and y counters are 0. Reset asserted mid-frame clears outputs immediately, with no frame completion. After release the block re-enters IDLE and begins a fresh frame only if start is high.
- States:
  - IDLE: on a clock edge with start = 1, frame_width != 0 and frame_height != 0, latch geometry and pattern_sel, set x = y = 0, go to RUN. The first beat presents tvalid = 1 with tuser = 1 in the cycle after that edge.
  - IDLE with start = 1 and either dimension 0: stay in IDLE; tvalid stays 0.
  - RUN: every output is registered. A beat completes on tvalid & tready. On completion x increments. When x = W-1, x wraps to 0 and y increments. On the beat with x = W-1 and y = H-1: frame_done pulses in the next cycle, then:
    - if start = 1, latch new geometry/pattern and continue with no idle cycle (tvalid stays high); if the new geometry contains a 0, go to IDLE.
    - if start = 0, go to IDLE.
- Backpressure: while tvalid = 1 and tready = 0, tdata, tlast and tuser hold stable. tvalid never drops mid-frame.
- Deasserting start mid-frame does not truncate the frame: the current frame completes, then the block idles.
- Changing frame_width, frame_height or pattern_sel mid-frame has no effect until the next frame start.
- Sideband: tuser = 1 only when x = 0 and y = 0; tlast = 1 only when x = W-1. For W = 1 every beat has tlast = 1.
- Pattern rule: b = one byte, replicated into every byte of tdata.
  - 0: b = x[7:0]
  - 1: b = y[7:0]
  - 2: b = 8'hFF if x[3]^y[3], else 8'h00
  - 3: tdata = SOLID_COLOR
- Counters are DIM_WIDTH bits wide; they cannot overflow because W and H are bounded by the port width.
- busy = 1 in RUN.

Optional Feature:
- Macro: VIDEO_STREAM_PATTERN_GEN_FRAME_CNT_EN.
- Defined: adds output port frame_count [31:0], reset 0. It increments in the cycle frame_done pulses and wraps from 32'hFFFFFFFF to 0. It is not cleared by start.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- W=4, H=2, pattern 0, tready always 1, start held 1 → beat 1 has tuser = 1; tdata sequence 000000, 010101, 020202, 030303 per line; tlast on beats 4 and 8; frame_done pulses once; next frame starts with no gap.
- Same setup, tready toggling pseudo-randomly → identical 8-beat sequence; tdata, tlast and tuser stable during every stall; tvalid never drops.
- W=16, H=16, pattern 2, start dropped after beat 3 → full 256-beat frame completes, then IDLE; beat (8,0) is FFFFFF, beat (8,8) is 000000.
- frame_width = 0, start = 1 → tvalid stays 0 and busy stays 0 for 100 cycles. Then set W=1, H=3 → three beats, each with tlast = 1.
- areset pulsed mid-frame (at beat 5 of 8) → tvalid and busy go 0 asynchronously. After release with start = 1, the next beat has tuser = 1 and tdata = 000000.
- With VIDEO_STREAM_PATTERN_GEN_FRAME_CNT_EN defined, run three W=2, H=2 frames → frame_count reads 3; pattern 3 beats equal 00FF00.
